// File: rtl/ddr_init_sequencer_if.sv
// Command handshake between the DDR init sequencer and the scheduler.
// The sequencer drives the command, the scheduler drives ready.
interface ddr_init_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [12:0] cmd_addr;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        output cmd_ready
    );
endinterface

// File: rtl/ddr_init_sequencer.sv
// DDR power-up init sequencer: PRECHARGE_ALL, LOAD_MODE, N x REFRESH,
// with registered outputs and timed waits between commands.
module ddr_init_sequencer #(
    parameter int T_PWRUP     = 200,
    parameter int T_RP        = 3,
    parameter int T_MRD       = 2,
    parameter int T_RFC       = 10,
    parameter int NUM_REFRESH = 2
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic                        cfg_valid,
    input  logic [2:0]                  cfg_cas_latency,
    input  logic [1:0]                  cfg_burst_len,
    ddr_init_sequencer_if.master        cmd,
    output logic                        busy,
    output logic                        init_done
);

    localparam int T_A   = (T_PWRUP > T_RP) ? T_PWRUP : T_RP;
    localparam int T_B   = (T_MRD > T_RFC) ? T_MRD : T_RFC;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam int RW    = $clog2(NUM_REFRESH + 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_PWRUP    = 4'd1;
    localparam logic [3:0] S_PRE      = 4'd2;
    localparam logic [3:0] S_WAIT_RP  = 4'd3;
    localparam logic [3:0] S_LMR      = 4'd4;
    localparam logic [3:0] S_WAIT_MRD = 4'd5;
    localparam logic [3:0] S_REF      = 4'd6;
    localparam logic [3:0] S_WAIT_RFC = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_PRE = 2'd1;
    localparam logic [1:0] OP_LMR = 2'd2;
    localparam logic [1:0] OP_REF = 2'd3;

    logic [3:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_ref;
    logic [2:0]    r_cas;
    logic [1:0]    r_bl;
    logic          r_valid;
    logic [1:0]    r_op;
    logic [12:0]   r_addr;
    logic          r_busy;
    logic          r_done;

    logic          w_start;
    logic          w_accept;
    logic          w_cnt_zero;
    logic [2:0]    w_bl_code;

    assign w_start    = start && cfg_valid;
    assign w_accept   = r_valid && cmd.cmd_ready;
    assign w_cnt_zero = (r_cnt == '0);

    // Map the snapshot burst-length select onto the mode-register code
    always_comb begin
        w_bl_code = 3'b011;
        case (r_bl)
            2'd0:    w_bl_code = 3'b001;
            2'd1:    w_bl_code = 3'b010;
            default: w_bl_code = 3'b011;
        endcase
    end

    // Sequence FSM: wait counter, refresh count, snapshot and outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ref   <= '0;
            r_cas   <= '0;
            r_bl    <= '0;
            r_valid <= 1'b0;
            r_op    <= OP_NOP;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state <= S_PWRUP;
                        r_cnt   <= CW'(T_PWRUP - 1);
                        r_ref   <= RW'(NUM_REFRESH);
                        r_cas   <= cfg_cas_latency;
                        r_bl    <= cfg_burst_len;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_PWRUP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_PRE;
                        r_valid <= 1'b1;
                        r_op    <= OP_PRE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_PRE: begin
                    if (w_accept) begin
                        r_state <= S_WAIT_RP;
                        r_valid <= 1'b0;
                        r_op    <= OP_NOP;
                        r_cnt   <= CW'(T_RP - 1);
                    end
                end
                S_WAIT_RP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_LMR;
                        r_valid <= 1'b1;
                        r_op    <= OP_LMR;
                        r_addr  <= {6'b0, r_cas, 1'b0, w_bl_code};
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_LMR: begin
                    if (w_accept) begin
                        r_state <= S_WAIT_MRD;
                        r_valid <= 1'b0;
                        r_op    <= OP_NOP;
                        r_addr  <= '0;
                        r_cnt   <= CW'(T_MRD - 1);
                    end
                end
                S_WAIT_MRD: begin
                    if (w_cnt_zero) begin
                        r_state <= S_REF;
                        r_valid <= 1'b1;
                        r_op    <= OP_REF;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_REF: begin
                    if (w_accept) begin
                        r_state <= S_WAIT_RFC;
                        r_valid <= 1'b0;
                        r_op    <= OP_NOP;
                        r_ref   <= r_ref - RW'(1);
                        r_cnt   <= CW'(T_RFC - 1);
                    end
                end
                S_WAIT_RFC: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (r_ref != '0) begin
                        r_state <= S_REF;
                        r_valid <= 1'b1;
                        r_op    <= OP_REF;
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_valid = r_valid;
    assign cmd.cmd_op    = r_op;
    assign cmd.cmd_addr  = r_addr;
    assign busy          = r_busy;
    assign init_done     = r_done;

endmodule

// File: tb/tb_ddr_init_sequencer.sv
// Bench for ddr_init_sequencer: scoreboard of expected commands with
// timing gaps, consumed by a monitor as the DUT issues them.
module tb_ddr_init_sequencer;

    typedef struct {
        int          kind;
        logic [12:0] addr;
        int          gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_cas_latency = 3'd0;
    logic [1:0] cfg_burst_len = 2'd0;
    logic       busy;
    logic       init_done;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    ddr_init_sequencer_if u_if();

    ddr_init_sequencer u_dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .start           (start),
        .cfg_valid       (cfg_valid),
        .cfg_cas_latency (cfg_cas_latency),
        .cfg_burst_len   (cfg_burst_len),
        .cmd             (u_if),
        .busy            (busy),
        .init_done       (init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_seq(input logic [12:0] lmr_addr);
        exp_q.push_back('{1, 13'h0, 200});
        exp_q.push_back('{2, lmr_addr, 3});
        exp_q.push_back('{3, 13'h0, 2});
        exp_q.push_back('{3, 13'h0, 10});
        exp_q.push_back('{4, 13'h0, 10});
    endfunction

    task automatic monitor();
        logic        prev_valid = 1'b0;
        logic        prev_done = 1'b0;
        logic        m_busy = 1'b0;
        int          ev_edge = 0;
        logic [1:0]  hold_op = 2'd0;
        logic [12:0] hold_addr = 13'h0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_valid = 1'b0;
                prev_done  = 1'b0;
                m_busy     = 1'b0;
            end else begin
                if (u_if.cmd_valid && !prev_valid) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_cmd: got op=%0d addr=%h at cycle %0d, want none",
                                 u_if.cmd_op, u_if.cmd_addr, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(u_if.cmd_op) !== e.kind || u_if.cmd_addr !== e.addr
                            || (cyc - ev_edge) !== e.gap) begin
                            n_err++;
                            $display("FAIL cmd_issue: got op=%0d addr=%h gap=%0d, want op=%0d addr=%h gap=%0d",
                                     u_if.cmd_op, u_if.cmd_addr, cyc - ev_edge,
                                     e.kind, e.addr, e.gap);
                        end
                    end
                    hold_op   = u_if.cmd_op;
                    hold_addr = u_if.cmd_addr;
                end else if (u_if.cmd_valid && prev_valid) begin
                    n_cmp++;
                    if (u_if.cmd_op !== hold_op || u_if.cmd_addr !== hold_addr) begin
                        n_err++;
                        $display("FAIL cmd_stable: got op=%0d addr=%h, want op=%0d addr=%h",
                                 u_if.cmd_op, u_if.cmd_addr, hold_op, hold_addr);
                    end
                end
                if (u_if.cmd_valid && u_if.cmd_ready) ev_edge = cyc + 1;
                if (init_done && !prev_done) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_done: got init_done=1 at cycle %0d, want 0", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind !== 4 || (cyc - ev_edge) !== e.gap || busy !== 1'b0) begin
                            n_err++;
                            $display("FAIL done_issue: got kind=4 gap=%0d busy=%b, want kind=%0d gap=%0d busy=0",
                                     cyc - ev_edge, busy, e.kind, e.gap);
                        end
                    end
                    m_busy = 1'b0;
                end
                if (start && cfg_valid && !m_busy) begin
                    m_busy  = 1'b1;
                    ev_edge = cyc + 1;
                end
                prev_valid = u_if.cmd_valid;
                prev_done  = init_done;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (init_done) break;
        end
        @(negedge clk);
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: got init_done=%b, want 1", tag, init_done);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL %s_leftover: got %0d pending, want 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        u_if.cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({u_if.cmd_valid, u_if.cmd_op, u_if.cmd_addr, busy, init_done} !== 18'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b op=%0d addr=%h busy=%b done=%b, want all 0",
                     u_if.cmd_valid, u_if.cmd_op, u_if.cmd_addr, busy, init_done);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    task automatic test_basic();
        cfg_valid = 1'b1;
        cfg_cas_latency = 3'd3;
        cfg_burst_len = 2'd2;
        push_seq(13'h033);
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || init_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy: got busy=%b done=%b, want busy=1 done=0", busy, init_done);
        end
        wait_done(400, "basic");
    endtask

    task automatic test_backpressure();
        do_reset();
        push_seq(13'h033);
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (u_if.cmd_valid && u_if.cmd_op == 2'd1) break;
        end
        @(posedge clk);
        #1;
        u_if.cmd_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (u_if.cmd_valid) break;
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (u_if.cmd_valid !== 1'b1 || u_if.cmd_op !== 2'd2 || u_if.cmd_addr !== 13'h033) begin
            n_err++;
            $display("FAIL bp_hold: got v=%b op=%0d addr=%h, want v=1 op=2 addr=033",
                     u_if.cmd_valid, u_if.cmd_op, u_if.cmd_addr);
        end
        @(posedge clk);
        #1;
        u_if.cmd_ready = 1'b1;
        wait_done(100, "bp");
    endtask

    task automatic test_no_cfg();
        logic seen = 1'b0;
        do_reset();
        cfg_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (u_if.cmd_valid || busy || init_done) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL nocfg_idle: got activity=1, want 0");
        end
        cfg_valid = 1'b1;
        push_seq(13'h033);
        pulse_start();
        wait_done(400, "nocfg_rerun");
    endtask

    task automatic test_snapshot();
        do_reset();
        cfg_cas_latency = 3'd3;
        cfg_burst_len = 2'd2;
        push_seq(13'h033);
        pulse_start();
        repeat (50) @(posedge clk);
        #1;
        cfg_cas_latency = 3'd5;
        cfg_burst_len = 2'd0;
        repeat (50) @(posedge clk);
        pulse_start();
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (u_if.cmd_valid && u_if.cmd_op == 2'd3) break;
        end
        pulse_start();
        wait_done(300, "snap");
        cfg_cas_latency = 3'd3;
        cfg_burst_len = 2'd2;
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        do_reset();
        push_seq(13'h033);
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (u_if.cmd_valid && u_if.cmd_op == 2'd3) break;
        end
        repeat (3) @(negedge clk);
        exp_q.delete();
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({u_if.cmd_valid, u_if.cmd_op, u_if.cmd_addr, busy, init_done} !== 18'h0) begin
            n_err++;
            $display("FAIL midreset_async: got v=%b op=%0d addr=%h busy=%b done=%b, want all 0",
                     u_if.cmd_valid, u_if.cmd_op, u_if.cmd_addr, busy, init_done);
        end
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (u_if.cmd_valid || busy || init_done) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_resume: got activity=1, want 0");
        end
    endtask

    task automatic test_restart();
        cfg_cas_latency = 3'd3;
        cfg_burst_len = 2'd2;
        push_seq(13'h033);
        pulse_start();
        wait_done(400, "restart_first");
        cfg_cas_latency = 3'd2;
        cfg_burst_len = 2'd0;
        push_seq(13'h021);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if (init_done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart_drop: got done=%b busy=%b, want done=0 busy=1", init_done, busy);
        end
        wait_done(400, "restart_second");
    endtask

    initial begin
        u_if.cmd_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_no_cfg();
        test_snapshot();
        test_reset_mid();
        test_restart();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ddr_init_sequencer.md
Name: ddr_init_sequencer

Overview:
Power-up initialization sequencer that sits directly downstream of config_register. On start it snapshots the CAS latency and burst length held in config_register. It then issues the DDR init command stream (PRECHARGE_ALL, LOAD_MODE, NUM_REFRESH × REFRESH) to the command scheduler over a valid/ready handshake, with the required inter-command waits. It asserts init_done when DRAM is ready for normal traffic.

Parameters:
T_PWRUP, 200, cycles from accepted start to first command valid
T_RP, 3, cycles from PRECHARGE_ALL accept to next command valid
T_MRD, 2, cycles from LOAD_MODE accept to next command valid
T_RFC, 10, cycles from each REFRESH accept to next command valid / init_done
NUM_REFRESH, 2, number of REFRESH commands (≥1)

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  single-cycle request to run init sequence
cfg_valid  in  1  config_register contents are valid
cfg_cas_latency  in  3  CAS latency code from config_register
cfg_burst_len  in  2  burst length select: 0→BL2, 1→BL4, 2→BL8, 3→BL8
cmd_ready  in  1  scheduler accepts command this cycle
cmd_valid  out  1  command presented
cmd_op  out  2  0 NOP, 1 PRECHARGE_ALL, 2 LOAD_MODE, 3 REFRESH
cmd_addr  out  13  mode word for LOAD_MODE, 0 otherwise
busy  out  1  sequence in progress
init_done  out  1  sequence complete

Behaviour:
- Reset (async assert, sync deassert use): state IDLE. Outputs cmd_valid=0, cmd_op=0, cmd_addr=0, busy=0, init_done=0. Counters and snapshot regs = 0.
- All outputs are registered.
- States: IDLE, PWRUP, PRE, WAIT_RP, LMR, WAIT_MRD, REF, WAIT_RFC, DONE.
- IDLE/DONE: start && cfg_valid → PWRUP on the next edge.
  - Snapshot cfg_cas_latency and cfg_burst_len.
  - busy=1, init_done=0.
  - start with cfg_valid=0 is ignored.
  - start while busy is ignored; the sequence does not restart.
- Wait timing rule: if an event occurs on edge k, the next cmd_valid (or init_done) rises exactly on edge k+T.
  - Event for PWRUP is start sampled.
  - Event for WAIT_* states is command accept.
  - Use one down-counter sized for max(T_*).
- PRE/LMR/REF:
  - cmd_valid=1 with matching cmd_op.
  - cmd_valid, cmd_op and cmd_addr are held stable until cmd_valid && cmd_ready.
  - On accept: cmd_valid drops the next cycle unless the next command is due.
  - Wait counter is loaded on accept.
- cmd_addr during LOAD_MODE:
  - [2:0] = burst code: 001 BL2, 010 BL4, 011 BL8.
  - [3] = 0 (sequential).
  - [6:4] = snapshot CAS latency.
  - [12:7] = 0.
- Refresh loop:
  - Refresh counter starts at NUM_REFRESH.
  - Decrements on each REF accept.
  - WAIT_RFC → REF while count ≠ 0, else → DONE.
- DONE: init_done=1, busy=0, cmd_valid=0. init_done is held until reset or an accepted restart.
- cfg changes mid-sequence have no effect (snapshot only).
- cmd_ready while cmd_valid=0 is ignored.
- Reset mid-sequence:
  - Immediately returns all outputs to reset values.
  - Any pending command is abandoned.
  - No resume after reset; a new start is required.

Test Plan:
- Reset then start=1 with cfg_valid=1, CL=3, burst_len=2, cmd_ready tied 1 → expected command stream:
  - PRE valid exactly 200 cycles after start edge.
  - LMR 3 cycles after PRE, cmd_addr=0x033.
  - REF 2 cycles after LMR.
  - Second REF 10 cycles after first REF.
  - init_done=1 10 cycles after second REF.
  - busy low at the same edge init_done rises.
- Backpressure: hold cmd_ready=0 for 5 cycles during LMR → cmd_valid, cmd_op=2 and cmd_addr stay stable. WAIT_MRD counts from the actual accept edge.
- start with cfg_valid=0 → stays IDLE, busy=0, no cmd_valid for 300 cycles. Repeat start with cfg_valid=1 → sequence runs.
- Change cfg_cas_latency to 5 mid-PWRUP → LMR cmd_addr[6:4] still reflects CL=3. start pulses during busy are ignored.
- Assert n_rst low during WAIT_RFC → all outputs 0 asynchronously (before next clk edge). After release, no command until a new start.
- From DONE, start with burst_len=0, CL=2 → init_done drops next cycle, full sequence reruns, LMR cmd_addr=0x021.
